bus_arbiter_2to1: RTL

Round-robin arbiter that shares one 32-bit beat-oriented resource port between two requesters. It grants one requester at a time for a burst of 1–2^BURST_W beats and drives the select of the shared 32-bit 2:1 data mux. It also generates the valid/last handshake toward the resource and per-requester beat-accept strobes. It sits between two bus masters (e.g. instruction fetch and data access) and a single memory/peripheral port.

---
 rtl/bus_arb_pkg.sv | 25 ++
 rtl/bus_arbiter_2to1_mux.sv | 15 +
 rtl/bus_arbiter_2to1.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and default sizes for the two-requester round-robin bus arbiter.
// Holds the FSM state encoding and the tie-break rule used at grant time.
package bus_arb_pkg;

   localparam int ARB_DATA_W  = 32;
   localparam int ARB_BURST_W = 4;
   localparam int ARB_TIMEOUT = 255;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arbState_e;

   // Returns the requester index to grant; a tie goes to whoever did not win last time.
   function automatic logic pickWinner(input logic req0, input logic req1, input logic lastWinner);
      logic w;
      if (req0 && req1) begin
         w = ~lastWinner;
      end else begin
         w = req1;
      end
      return w;
   endfunction

endpackage

// File: rtl/bus_arbiter_2to1_mux.sv
// Team 2:1 data mux shared by both requesters; select 0 passes i_bitA, 1 passes i_bitB.
module Mux2to1_32bit
   import bus_arb_pkg::*;
#(
   parameter int W = ARB_DATA_W
) (
   input  logic [W-1:0] i_bitA,
   input  logic [W-1:0] i_bitB,
   input  logic         i_bitS,
   output logic [W-1:0] o_bitY
);

   assign o_bitY = i_bitS ? i_bitB : i_bitA;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin 2:1 burst arbiter driving a shared beat port and its data mux.
// Define ARB_TIMEOUT_EN to add a stall watchdog that aborts a stuck burst and pulses o_err.
module bus_arbiter_2to1
   import bus_arb_pkg::*;
#(
   parameter int DATA_W  = ARB_DATA_W,
   parameter int BURST_W = ARB_BURST_W
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = ARB_TIMEOUT
`endif
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic [BURST_W-1:0] i_len0,
   input  logic [BURST_W-1:0] i_len1,
   input  logic [DATA_W-1:0] i_data0,
   input  logic [DATA_W-1:0] i_data1,
   input  logic              i_ready,
   output logic              o_gnt0,
   output logic              o_gnt1,
   output logic              o_ack0,
   output logic              o_ack1,
   output logic              o_sel,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_err
);

   arbState_e          state_q, state_d;
   logic               gnt0_q, gnt0_d;
   logic               gnt1_q, gnt1_d;
   logic               sel_q, sel_d;
   logic               lastWinner_q, lastWinner_d;
   logic [BURST_W-1:0] beatCnt_q, beatCnt_d;
   logic               winner;
   logic               accept;

`ifdef ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT + 1);
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               err_q, err_d;
`endif

   assign winner = pickWinner(i_req0, i_req1, lastWinner_q);
   assign accept = (state_q == XFER) && i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         sel_q        <= 1'b0;
         lastWinner_q <= 1'b1;
         beatCnt_q    <= '0;
`ifdef ARB_TIMEOUT_EN
         stall_q      <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         sel_q        <= sel_d;
         lastWinner_q <= lastWinner_d;
         beatCnt_q    <= beatCnt_d;
`ifdef ARB_TIMEOUT_EN
         stall_q      <= stall_d;
         err_q        <= err_d;
`endif
      end
   end

   // Requests are only looked at in IDLE, so anything raised mid-burst waits for the turnaround cycle.
   always_comb begin
      state_d      = state_q;
      gnt0_d       = gnt0_q;
      gnt1_d       = gnt1_q;
      sel_d        = sel_q;
      lastWinner_d = lastWinner_q;
      beatCnt_d    = beatCnt_q;
      case (state_q)
         IDLE: begin
            if (i_req0 || i_req1) begin
               state_d      = XFER;
               gnt0_d       = ~winner;
               gnt1_d       = winner;
               sel_d        = winner;
               lastWinner_d = winner;
               beatCnt_d    = winner ? i_len1 : i_len0;
            end
         end
         XFER: begin
            if (accept) begin
               if (beatCnt_q == '0) begin
                  state_d = IDLE;
                  gnt0_d  = 1'b0;
                  gnt1_d  = 1'b0;
               end else begin
                  beatCnt_d = beatCnt_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
      endcase
`ifdef ARB_TIMEOUT_EN
      stall_d = '0;
      err_d   = 1'b0;
      // The abort fires on the stall cycle that brings the run of consecutive stalls up to TIMEOUT.
      if ((state_q == XFER) && !i_ready) begin
         if (stall_q == STALL_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            err_d   = 1'b1;
         end else begin
            stall_d = stall_q + 1'b1;
         end
      end
`endif
   end

   always_comb begin
      o_valid = 1'b0;
      o_busy  = 1'b0;
      o_last  = 1'b0;
      if (state_q == XFER) begin
         o_valid = 1'b1;
         o_busy  = 1'b1;
         o_last  = (beatCnt_q == '0);
      end
   end

   assign o_gnt0 = gnt0_q;
   assign o_gnt1 = gnt1_q;
   assign o_ack0 = gnt0_q & i_ready;
   assign o_ack1 = gnt1_q & i_ready;
   assign o_sel  = sel_q;

`ifdef ARB_TIMEOUT_EN
   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

   Mux2to1_32bit #(
      .W(DATA_W)
   ) dataMux (
      .i_bitA(i_data0),
      .i_bitB(i_data1),
      .i_bitS(sel_q),
      .o_bitY(o_data)
   );

endmodule
